// File: rtl/instr_realign_buf.sv
// Fetch-stage instruction realigner: splits fetch blocks into 16/32-bit instructions and queues them with PC.
// Define REALIGN_RVC_EN for compressed support; without it every aligned 32-bit word is one instruction.
module instr_realign_buf #(
  parameter int FETCH_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [FETCH_W-1:0]     fetch_data_i,
  input  logic [31:0]            fetch_pc_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [31:0]            instr_o,
  output logic [31:0]            instr_pc_o,
  output logic                   instr_compressed_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int NSLOT = FETCH_W / 16;
  localparam int NWORD = FETCH_W / 32;
  localparam int OFFW  = $clog2(FETCH_W / 8);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
`ifdef REALIGN_RVC_EN
  localparam int NEED  = NSLOT;
`else
  localparam int NEED  = NWORD;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          head_q, head_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            accept;
  logic            pop;
  logic [CW-1:0]   n_push;
  logic [PW-1:0]   wa;
  logic [31:0]     base;

`ifdef REALIGN_RVC_EN
  logic            pend_q, pend_d;
  logic [15:0]     pend_hw_q, pend_hw_d;
  logic [31:0]     pend_pc_q, pend_pc_d;
  logic [FETCH_W+15:0] data_ext;
  logic [OFFW-2:0] start_slot;
  logic [15:0]     hw;
  logic            skip;
  logic            pend_live;

  assign data_ext   = {16'h0000, fetch_data_i};
  assign start_slot = fetch_pc_i[OFFW-1:1];
`else
  logic [OFFW-1:0] start_word;

  assign start_word = fetch_pc_i[OFFW-1:0] >> 2;
`endif

  assign base          = {fetch_pc_i[31:OFFW], {OFFW{1'b0}}};
  assign fetch_ready_o = !flush_i && (count_q <= CW'(DEPTH - NEED));
  assign accept        = fetch_valid_i && fetch_ready_o;
  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    head_d   = head_q;
    n_push   = '0;
    wa       = wr_ptr_q;
`ifdef REALIGN_RVC_EN
    pend_d    = pend_q;
    pend_hw_d = pend_hw_q;
    pend_pc_d = pend_pc_q;
    hw        = '0;
    skip      = 1'b0;
    pend_live = 1'b0;
    if (accept) begin
      // A discontinuous block silently drops any held first half.
      pend_live = pend_q && (fetch_pc_i == pend_pc_q + 32'd2);
      pend_d    = 1'b0;
      for (int s = 0; s < NSLOT; s++) begin
        hw = data_ext[16*s +: 16];
        wa = wr_ptr_q + n_push[PW-1:0];
        if (s >= int'(start_slot)) begin
          if (skip) begin
            skip = 1'b0;
          end else if (pend_live) begin
            mem_d[wa] = {hw, pend_hw_q, pend_pc_q, 1'b0};
            n_push    = n_push + CW'(1);
            pend_live = 1'b0;
          end else if (hw[1:0] != 2'b11) begin
            mem_d[wa] = {16'h0000, hw, base + 32'(2*s), 1'b1};
            n_push    = n_push + CW'(1);
          end else if (s + 1 < NSLOT) begin
            mem_d[wa] = {data_ext[16*(s+1) +: 16], hw, base + 32'(2*s), 1'b0};
            n_push    = n_push + CW'(1);
            skip      = 1'b1;
          end else begin
            pend_d    = 1'b1;
            pend_hw_d = hw;
            pend_pc_d = base + 32'(2*s);
          end
        end
      end
    end
`else
    if (accept) begin
      for (int s = 0; s < NWORD; s++) begin
        wa = wr_ptr_q + n_push[PW-1:0];
        if (s >= int'(start_word)) begin
          mem_d[wa] = {fetch_data_i[32*s +: 32], base + 32'(4*s), 1'b0};
          n_push    = n_push + CW'(1);
        end
      end
    end
`endif

    wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + n_push - {{(CW-1){1'b0}}, pop};

    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
`ifdef REALIGN_RVC_EN
      pend_d   = 1'b0;
`endif
    end

    // Head is re-registered so an empty queue keeps showing the last instruction.
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef REALIGN_RVC_EN
      pend_q    <= 1'b0;
      pend_hw_q <= '0;
      pend_pc_q <= '0;
`endif
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
`ifdef REALIGN_RVC_EN
      pend_q    <= pend_d;
      pend_hw_q <= pend_hw_d;
      pend_pc_q <= pend_pc_d;
`endif
    end
  end

  assign instr_o            = head_q.instr;
  assign instr_pc_o         = head_q.pc;
  assign instr_compressed_o = head_q.comp;
  assign count_o            = count_q;

endmodule

// File: tb/tb_instr_realign_buf.sv
// Scoreboard bench for instr_realign_buf: a PC-walking reference model fills an expected queue,
// a negedge monitor compares the DUT head, occupancy and ready against it.
module tb_instr_realign_buf;

  localparam int FW  = 32;
  localparam int DEP = 4;
`ifdef REALIGN_RVC_EN
  localparam int NEED = FW / 16;
`else
  localparam int NEED = FW / 32;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  fetch_valid_i;
  logic                  fetch_ready_o;
  logic [FW-1:0]         fetch_data_i;
  logic [31:0]           fetch_pc_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [31:0]           instr_o;
  logic [31:0]           instr_pc_o;
  logic                  instr_compressed_o;
  logic [$clog2(DEP):0]  count_o;

  instr_realign_buf #(.FETCH_W(FW), .DEPTH(DEP)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_data_i       (fetch_data_i),
    .fetch_pc_i         (fetch_pc_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_compressed_o (instr_compressed_o),
    .count_o            (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  exp_t        q[$];
  logic        m_pend;
  logic [15:0] m_pend_hw;
  logic [31:0] m_pend_pc;
  logic [31:0] last_instr;
  logic [31:0] last_pc;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: walk the block by byte offset from the requested PC.
  task automatic model_block(input logic [FW-1:0] d, input logic [31:0] pc);
    int unsigned bytes, off;
    logic [31:0] base;
    bytes = FW / 8;
    base  = pc & ~(bytes - 1);
    off   = pc - base;
`ifdef REALIGN_RVC_EN
    begin
      logic [FW+15:0] dx;
      logic [15:0]    hw, hw2;
      logic           cont;
      dx     = {16'h0000, d};
      cont   = m_pend && (pc == m_pend_pc + 32'd2);
      m_pend = 1'b0;
      while (off < bytes) begin
        hw = dx[off*8 +: 16];
        if (cont) begin
          q.push_back('{{hw, m_pend_hw}, m_pend_pc, 1'b0});
          cont = 1'b0;
          off += 2;
        end else if (hw[1:0] != 2'b11) begin
          q.push_back('{{16'h0000, hw}, base + off, 1'b1});
          off += 2;
        end else if (off + 2 < bytes) begin
          hw2 = dx[(off+2)*8 +: 16];
          q.push_back('{{hw2, hw}, base + off, 1'b0});
          off += 4;
        end else begin
          m_pend    = 1'b1;
          m_pend_hw = hw;
          m_pend_pc = base + off;
          off += 2;
        end
      end
    end
`else
    off = off & ~32'd3;
    while (off < bytes) begin
      q.push_back('{d[off*8 +: 32], base + off, 1'b0});
      off += 4;
    end
`endif
  endtask

  // Monitor / scoreboard: everything here reflects state between edges.
  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
      m_pend     = 1'b0;
      last_instr = '0;
      last_pc    = '0;
    end else begin
      check("count", 64'(count_o), 64'(q.size()));
      check("fetch_ready", 64'(fetch_ready_o), 64'(!flush_i && (DEP - q.size() >= NEED)));
      check("instr_valid", 64'(instr_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("instr", 64'(instr_o), 64'(q[0].instr));
        check("instr_pc", 64'(instr_pc_o), 64'(q[0].pc));
        check("compressed", 64'(instr_compressed_o), 64'(q[0].comp));
        last_instr = q[0].instr;
        last_pc    = q[0].pc;
      end else begin
        check("hold_instr", 64'(instr_o), 64'(last_instr));
        check("hold_pc", 64'(instr_pc_o), 64'(last_pc));
      end
      if (flush_i) begin
        q.delete();
        m_pend = 1'b0;
      end else begin
        if (instr_valid_o && instr_ready_i && q.size() != 0) void'(q.pop_front());
        if (fetch_valid_i && fetch_ready_o) model_block(fetch_data_i, fetch_pc_i);
      end
    end
  end

  task automatic send(input logic [FW-1:0] d, input logic [31:0] pc);
    bit done;
    done          = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_data_i  = d;
    fetch_pc_i    = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      done = fetch_ready_o;
      @(posedge clk_i);
      #1;
    end
    fetch_valid_i = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 for pc 0x%0h", pc);
    end
  endtask

  task automatic drain();
    instr_ready_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_block();
    logic [FW-1:0] d;
    d = '0;
    for (int i = 0; i < FW / 16; i++) begin
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      d[16*i +: 16] = h;
    end
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_base;
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = '0;
    fetch_pc_i    = '0;
    instr_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(fetch_ready_o), 64'd1);
    check("rst_valid", 64'(instr_valid_o), 64'd0);
    check("rst_instr", 64'(instr_o), 64'd0);
    check("rst_pc", 64'(instr_pc_o), 64'd0);
    @(posedge clk_i); #1;

    // single 32-bit instruction, one-cycle latency
    send(32'h0000_0013, 32'h1000);
    @(negedge clk_i);
    check("t2_count", 64'(count_o), 64'd1);
    check("t2_instr", 64'(instr_o), 64'h13);
    check("t2_pc", 64'(instr_pc_o), 64'h1000);
    check("t2_comp", 64'(instr_compressed_o), 64'd0);
    @(posedge clk_i); #1;
    drain();

    // two compressed, then a straddling 32-bit instruction
    send(32'h4501_4501, 32'h1000);
    drain();
    send(32'h0013_4501, 32'h1000);
    send(32'h4501_0000, 32'h1004);
    drain();

    // backpressure
    instr_ready_i = 1'b0;
    send(32'h4501_4501, 32'h1000);
    send(32'h4501_4501, 32'h1004);
`ifdef REALIGN_RVC_EN
    @(negedge clk_i);
    check("t5_count_full", 64'(count_o), 64'd4);
    check("t5_ready_full", 64'(fetch_ready_o), 64'd0);
    @(posedge clk_i); #1 instr_ready_i = 1'b1;
    @(posedge clk_i); #1 instr_ready_i = 1'b0;
    @(negedge clk_i);
    check("t5_count_3", 64'(count_o), 64'd3);
    check("t5_ready_3", 64'(fetch_ready_o), 64'd0);
    @(posedge clk_i); #1 instr_ready_i = 1'b1;
    @(posedge clk_i); #1 instr_ready_i = 1'b0;
    @(negedge clk_i);
    check("t5_count_2", 64'(count_o), 64'd2);
    check("t5_ready_2", 64'(fetch_ready_o), 64'd1);
    @(posedge clk_i); #1;
`endif
    drain();

    // flush discards a pending half
    instr_ready_i = 1'b0;
    send(32'h0013_4501, 32'h1000);
    flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    send(32'h4501_0013, 32'h2002);
`ifdef REALIGN_RVC_EN
    @(negedge clk_i);
    check("t6_count", 64'(count_o), 64'd1);
    check("t6_instr", 64'(instr_o), 64'h4501);
    check("t6_pc", 64'(instr_pc_o), 64'h2002);
    check("t6_comp", 64'(instr_compressed_o), 64'd1);
    @(posedge clk_i); #1;
`endif
    drain();

    // randomized traffic with a mid-run asynchronous reset
    prev_base = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      fetch_valid_i = ($urandom_range(0, 9) < 7);
      fetch_data_i  = rand_block();
      if ($urandom_range(0, 1) == 1) begin
        prev_base  = prev_base + FW / 8;
        fetch_pc_i = prev_base;
      end else begin
        prev_base  = 32'h1000 + 32'($urandom_range(0, 63)) * (FW / 8);
        fetch_pc_i = prev_base + 32'($urandom_range(0, FW / 16 - 1)) * 2;
      end
      instr_ready_i = ($urandom_range(0, 9) < 6);
      flush_i       = ($urandom_range(0, 99) < 3);
      if (c == 300) begin
        #2;
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        #1;
        check("arst_valid", 64'(instr_valid_o), 64'd0);
        check("arst_instr", 64'(instr_o), 64'd0);
        check("arst_pc", 64'(instr_pc_o), 64'd0);
        check("arst_comp", 64'(instr_compressed_o), 64'd0);
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_ready", 64'(fetch_ready_o), 64'd1);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
    end
    fetch_valid_i = 1'b0;
    flush_i       = 1'b0;
    drain();
    @(negedge clk_i);
    check("final_count", 64'(count_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_realign_buf.md
Name: instr_realign_buf

Overview:
Parametrised instruction realigner with an output queue, for the fetch stage, between the i$ and decode.
- Accepts FETCH_W-bit blocks via valid/ready.
- Splits each block into 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle two blocks.
- Queues each instruction with its PC and a compressed flag.
- Replaces the stall-on-compressed scheme with a proper decoupling FIFO.

Parameters:
FETCH_W, 32, fetch block width in bits; 32 or 64.
DEPTH, 4, instruction queue entries; power of two, >= FETCH_W/16.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  discard queue and pending half-instruction
fetch_valid_i  in  1  block valid
fetch_ready_o  out  1  block can be accepted
fetch_data_i  in  FETCH_W  fetch block, little-endian halfwords
fetch_pc_i  in  32  PC of first wanted halfword; bit0 = 0
instr_valid_o  out  1  queue head valid
instr_ready_i  in  1  decode consumes head
instr_o  out  32  instruction; compressed entries zero-extended {16'h0, hw}
instr_pc_o  out  32  instruction PC
instr_compressed_o  out  1  head is a 16-bit instruction
count_o  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (async): queue empty, pending flag 0, pending halfword/PC 0.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_compressed_o=0, count_o=0, fetch_ready_o=1.
- Block accept:
  - A block is accepted when fetch_valid_i && fetch_ready_o.
  - fetch_ready_o = !flush_i && (DEPTH - count_o >= NSLOT), where NSLOT = FETCH_W/16. This is the worst-case push count per block.
- Extraction of an accepted block:
  - Block base = fetch_pc_i with bits [$clog2(FETCH_W/8)-1:0] cleared.
  - Start slot = fetch_pc_i[$clog2(FETCH_W/8)-1:1]. Halfwords below the start slot are ignored.
  - Scan slots ascending:
    - If the pending flag is set and fetch_pc_i == pending_pc+2, slot s completes the instruction {hw[s], pending_hw} at pending_pc, and the pending flag clears.
    - If the pending flag is set and fetch_pc_i != pending_pc+2 (discontinuity), the pending half is dropped with no push, and the scan proceeds normally.
    - If hw[1:0] != 2'b11, push a compressed entry at PC base+2s. hw = 16'h0000 is also pushed as compressed; decode flags it illegal.
    - Otherwise, if s+1 < NSLOT, push {hw[s+1], hw[s]} at base+2s and skip s+1.
    - Otherwise (last slot), store hw[s] and base+2s as pending and set the pending flag. Nothing is pushed.
  - All pushes from one block are written in the same cycle. The queue is ordered by ascending PC.
- Latency: a block accepted at edge N makes its first instruction visible (instr_valid_o=1) after edge N, i.e. in cycle N+1. Outputs come from registered queue storage.
- Pop: on instr_valid_o && instr_ready_i. Pop and push in the same cycle are both honoured; count_o = count - pop + pushes.
- Pointers: read/write pointers wrap modulo DEPTH. Full vs empty is distinguished by count, never by pointer equality alone.
- Empty queue: instr_valid_o=0, and instr_o/instr_pc_o hold the last head value.
- Flush:
  - flush_i has priority over everything else.
  - Next edge: queue empty, pending flag 0, count_o=0.
  - Any block presented in the flush cycle is not accepted (fetch_ready_o=0), and any pop in the flush cycle is ignored.
- Reset mid-operation behaves like flush plus output clearing, asynchronously.

Optional Feature:
REALIGN_RVC_EN
- Defined: compressed support exactly as above.
- Undefined: every 32-bit aligned word is one instruction.
  - instr_compressed_o tied 0, pending logic absent.
  - fetch_pc_i[1] ignored; start word = fetch_pc_i[$clog2(FETCH_W/8)-1:2].
  - fetch_ready_o requires FETCH_W/32 free entries.

Test Plan:
(FETCH_W=32, DEPTH=4, REALIGN_RVC_EN defined)
1. Reset with rst_i=1 asserted mid-traffic -> all outputs 0 immediately, fetch_ready_o=1, count_o=0 after release.
2. Block 32'h00000013 @0x1000 -> next cycle: instr_o=0x00000013, instr_pc_o=0x1000, compressed=0, count_o=1.
3. Block 32'h45014501 @0x1000, instr_ready_i=1 -> 0x00004501 @0x1000 then 0x00004501 @0x1002, compressed=1 on both.
4. Straddle: 32'h00134501 @0x1000, then 32'h45010000 @0x1004 -> 0x00004501 @0x1000, 0x00000013 @0x1002 (compressed=0), 0x00004501 @0x1006.
5. Backpressure with instr_ready_i=0: two 32'h45014501 blocks -> count_o=4, fetch_ready_o=0. Pop 1 -> still 0. Pop 2nd -> fetch_ready_o=1.
6. 32'h00134501 @0x1000 (pending set), then flush_i pulse, then 32'h45010013 @0x2002 -> only 0x00004501 @0x2002. No stale 0x0013 completion; count_o=1.
